// File: rtl/ssram8k_video_fetcher.sv
// rtl/ssram8k_video_fetcher.sv - screen SRAM line fetcher with host write arbitration
// Reads 32 bitmap/attribute cell pairs per display line and streams them out.
module ssram8k_video_fetcher #(
  parameter int          LINES     = 192,
  parameter logic [12:0] ATTR_BASE = 13'h1800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  output logic        line_busy,
  output logic        line_done,
  output logic        cell_valid,
  input  logic        cell_ready,
  output logic [7:0]  cell_pixels,
  output logic [7:0]  cell_attr,
  output logic [4:0]  cell_col,
  output logic        cell_last,
  input  logic        wr_req,
  input  logic [12:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        ce,
  output logic        wre,
  output logic [12:0] ad,
  inout  wire  [7:0]  data_bus
);

  localparam logic [8:0] LINES_W = 9'(LINES);

  typedef enum logic [2:0] {
    S_IDLE, S_BM_ADDR, S_BM_DATA, S_AT_ADDR, S_AT_DATA, S_PUSH, S_WR
  } state_t;

  state_t      state_q, state_d, ret_q, ret_d, nxt_s;
  logic [7:0]  y_q, y_d;
  logic [4:0]  x_q, x_d;
  logic [7:0]  pix_q, pix_d, attr_q, attr_d;
  logic        cell_valid_q, cell_valid_d;
  logic [7:0]  cell_pixels_q, cell_pixels_d;
  logic [7:0]  cell_attr_q, cell_attr_d;
  logic [4:0]  cell_col_q, cell_col_d;
  logic        cell_last_q, cell_last_d;
  logic        line_busy_q, line_busy_d;
  logic        line_done_q, line_done_d;
  logic        accept;
  logic [12:0] bm_addr, at_addr;

  assign bm_addr = {y_q[7], y_q[6], y_q[2:0], y_q[5:3], x_q};
  assign at_addr = ATTR_BASE + {3'b000, y_q[7:3], x_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ret_q         <= S_IDLE;
      y_q           <= '0;
      x_q           <= '0;
      pix_q         <= '0;
      attr_q        <= '0;
      cell_valid_q  <= 1'b0;
      cell_pixels_q <= '0;
      cell_attr_q   <= '0;
      cell_col_q    <= '0;
      cell_last_q   <= 1'b0;
      line_busy_q   <= 1'b0;
      line_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      y_q           <= y_d;
      x_q           <= x_d;
      pix_q         <= pix_d;
      attr_q        <= attr_d;
      cell_valid_q  <= cell_valid_d;
      cell_pixels_q <= cell_pixels_d;
      cell_attr_q   <= cell_attr_d;
      cell_col_q    <= cell_col_d;
      cell_last_q   <= cell_last_d;
      line_busy_q   <= line_busy_d;
      line_done_q   <= line_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    nxt_s         = S_IDLE;
    y_d           = y_q;
    x_d           = x_q;
    pix_d         = pix_q;
    attr_d        = attr_q;
    cell_valid_d  = cell_valid_q;
    cell_pixels_d = cell_pixels_q;
    cell_attr_d   = cell_attr_q;
    cell_col_d    = cell_col_q;
    cell_last_d   = cell_last_q;
    line_busy_d   = line_busy_q;
    line_done_d   = 1'b0;
    accept        = cell_valid_q && cell_ready;

    // The line only ends once its column-31 cell has left the output register.
    if (accept) begin
      cell_valid_d = 1'b0;
      if (cell_last_q) begin
        line_busy_d = 1'b0;
        line_done_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          state_d = S_WR;
          ret_d   = S_IDLE;
        end else if (line_start && !line_busy_q && ({1'b0, line_y} < LINES_W)) begin
          y_d         = line_y;
          x_d         = '0;
          line_busy_d = 1'b1;
          state_d     = S_BM_ADDR;
        end
      end
      S_BM_ADDR: state_d = S_BM_DATA;
      S_BM_DATA: begin
        pix_d = data_bus;
        if (wr_req) begin
          state_d = S_WR;
          ret_d   = S_AT_ADDR;
        end else begin
          state_d = S_AT_ADDR;
        end
      end
      S_AT_ADDR: state_d = S_AT_DATA;
      S_AT_DATA: begin
        attr_d  = data_bus;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        if (!cell_valid_q || cell_ready) begin
          cell_valid_d  = 1'b1;
          cell_pixels_d = pix_q;
          cell_attr_d   = attr_q;
          cell_col_d    = x_q;
          cell_last_d   = (x_q == 5'd31);
          if (x_q == 5'd31) begin
            nxt_s = S_IDLE;
          end else begin
            x_d   = x_q + 5'd1;
            nxt_s = S_BM_ADDR;
          end
          if (wr_req) begin
            state_d = S_WR;
            ret_d   = nxt_s;
          end else begin
            state_d = nxt_s;
          end
        end
      end
      S_WR:    state_d = ret_q;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus signals decode straight from state so reset drops ce without a clock.
  always_comb begin
    ce  = 1'b0;
    wre = 1'b0;
    ad  = '0;
    case (state_q)
      S_BM_ADDR, S_BM_DATA: begin
        ce = 1'b1;
        ad = bm_addr;
      end
      S_AT_ADDR, S_AT_DATA: begin
        ce = 1'b1;
        ad = at_addr;
      end
      S_WR: begin
        ce  = 1'b1;
        wre = 1'b1;
        ad  = wr_addr;
      end
      default: ;
    endcase
  end

  assign data_bus    = (ce && wre) ? wr_data : 8'bz;
  assign wr_ack      = (state_q == S_WR);
  assign line_busy   = line_busy_q;
  assign line_done   = line_done_q;
  assign cell_valid  = cell_valid_q;
  assign cell_pixels = cell_pixels_q;
  assign cell_attr   = cell_attr_q;
  assign cell_col    = cell_col_q;
  assign cell_last   = cell_last_q;

endmodule

// File: tb/tb_ssram8k_video_fetcher.sv
// tb/tb_ssram8k_video_fetcher.sv - directed scoreboard bench for ssram8k_video_fetcher
// Models the registered-output screen SRAM and checks cells, addresses and handshakes.
module tb_ssram8k_video_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  line_y = '0;
  logic        line_busy, line_done, cell_valid, cell_last;
  logic        cell_ready = 1'b0;
  logic [7:0]  cell_pixels, cell_attr;
  logic [4:0]  cell_col;
  logic        wr_req = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack, ce, wre;
  logic [12:0] ad;
  wire  [7:0]  data_bus;

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] attr;
    logic [4:0] col;
    logic       last;
  } cell_t;

  cell_t       sb[$];
  cell_t       mon_e;
  logic [12:0] ad_log[$];
  logic [7:0]  mem     [0:8191];
  logic [7:0]  ref_mem [0:8191];
  logic [7:0]  sram_q = '0;
  bit          mem_init = 1'b0;
  int          checks = 0, errors = 0;
  int          ce_cnt = 0, rd_cnt = 0, done_cnt = 0, ack_cnt = 0;
  bit          hold_v = 1'b0;
  logic [21:0] hold_bits = '0;

  ssram8k_video_fetcher dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .line_busy(line_busy), .line_done(line_done), .cell_valid(cell_valid),
    .cell_ready(cell_ready), .cell_pixels(cell_pixels), .cell_attr(cell_attr),
    .cell_col(cell_col), .cell_last(cell_last), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .ce(ce), .wre(wre), .ad(ad), .data_bus(data_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(int i);
    if (i == 0)       return 8'hAA;
    if (i == 'h1800)  return 8'h38;
    if (i == 'h1234)  return 8'h11;
    return 8'(i * 7 + (i >> 8));
  endfunction

  function automatic logic [12:0] bm_of(logic [7:0] y, logic [4:0] x);
    return {y[7], y[6], y[2], y[1], y[0], y[5], y[4], y[3], x};
  endfunction

  function automatic logic [12:0] at_of(logic [7:0] y, logic [4:0] x);
    return 13'h1800 + {3'b000, y[7:3], x};
  endfunction

  // SRAM: read data registered on the ADDR cycle, presented during the DATA cycle.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else begin
      if (ce && !wre) sram_q <= mem[ad];
      if (ce && wre) mem[ad] <= data_bus;
    end
  end

  assign data_bus = (ce && !wre) ? sram_q : 8'bz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ce) ce_cnt++;
      if (ce && !wre) begin
        rd_cnt++;
        ad_log.push_back(ad);
      end
      if (line_done) done_cnt++;
      if (wr_ack) ack_cnt++;
      if (hold_v && cell_valid)
        check("cell_stable", {cell_pixels, cell_attr, cell_col, cell_last}, hold_bits);
      hold_v    = cell_valid && !cell_ready;
      hold_bits = {cell_pixels, cell_attr, cell_col, cell_last};
      if (cell_valid && cell_ready) begin
        check("cell_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("cell_pixels", cell_pixels, mon_e.pix);
          check("cell_attr", cell_attr, mon_e.attr);
          check("cell_col", cell_col, mon_e.col);
          check("cell_last", cell_last, mon_e.last);
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [7:0] y);
    cell_t c;
    for (int x = 0; x < 32; x++) begin
      c.pix  = ref_mem[bm_of(y, 5'(x))];
      c.attr = ref_mem[at_of(y, 5'(x))];
      c.col  = 5'(x);
      c.last = (x == 31);
      sb.push_back(c);
    end
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (line_done) begin
        got = 1'b1;
        break;
      end
    end
    check("line_done_seen", 32'(got), 1);
  endtask

  task automatic run_line(input logic [7:0] y);
    int r0, d0;
    ad_log.delete();
    r0 = rd_cnt;
    d0 = done_cnt;
    push_line(y);
    line_y     = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_done(2000);
    tick();
    check("line_done_once", done_cnt - d0, 1);
    check("sb_drained", sb.size(), 0);
    check("reads_per_line", rd_cnt - r0, 128);
    check("busy_after_line", line_busy, 0);
  endtask

  initial begin
    int c0, r0, d0, a0;
    bit seen;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    repeat (3) tick();
    check("rst_ce", ce, 0);
    check("rst_wre", wre, 0);
    check("rst_ad", ad, 0);
    check("rst_busy", line_busy, 0);
    check("rst_done", line_done, 0);
    check("rst_valid", cell_valid, 0);
    check("rst_pixels", cell_pixels, 0);
    check("rst_attr", cell_attr, 0);
    check("rst_col", cell_col, 0);
    check("rst_last", cell_last, 0);
    check("rst_ack", wr_ack, 0);
    reset = 1'b0;
    tick();

    // Basic line 0 with ad sequence of first cell
    cell_ready = 1'b1;
    run_line(8'd0);
    check("l0_ad0", ad_log[0], 13'h0000);
    check("l0_ad1", ad_log[1], 13'h0000);
    check("l0_ad2", ad_log[2], 13'h1800);
    check("l0_ad3", ad_log[3], 13'h1800);

    // Address mapping
    run_line(8'd1);
    check("y1_bm", ad_log[0], 13'h0100);
    run_line(8'd8);
    check("y8_bm", ad_log[0], 13'h0020);
    run_line(8'd64);
    check("y64_bm", ad_log[0], 13'h0800);
    run_line(8'd191);
    check("y191_bm31", ad_log[124], 13'h17FF);
    check("y191_at31", ad_log[126], 13'h1AFF);

    // Backpressure
    cell_ready = 1'b0;
    r0 = rd_cnt;
    d0 = done_cnt;
    push_line(8'd2);
    line_y     = 8'd2;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cell_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("bp_first_valid", 32'(seen), 1);
    repeat (20) tick();
    check("bp_valid_held", cell_valid, 1);
    check("bp_col_held", cell_col, 0);
    check("bp_reads_stalled", rd_cnt - r0, 8);
    cell_ready = 1'b1;
    wait_done(2000);
    tick();
    check("bp_done_once", done_cnt - d0, 1);
    check("bp_sb_drained", sb.size(), 0);

    // Host write during BM_DATA of line 138, col 0; 0x1234 is bitmap of col 20
    ref_mem[13'h1234] = 8'h5A;
    a0 = ack_cnt;
    d0 = done_cnt;
    push_line(8'd138);
    line_y     = 8'd138;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    wr_addr = 13'h1234;
    wr_data = 8'h5A;
    wr_req  = 1'b1;
    tick();
    check("wr_ack_hi", wr_ack, 1);
    check("wr_ce", ce, 1);
    check("wr_wre", wre, 1);
    check("wr_ad", ad, 13'h1234);
    check("wr_bus", data_bus, 8'h5A);
    wr_req = 1'b0;
    tick();
    check("wr_ack_lo", wr_ack, 0);
    check("after_wr_wre", wre, 0);
    check("after_wr_ad", ad, 13'h1A20);
    wait_done(2000);
    tick();
    check("wr_ack_once", ack_cnt - a0, 1);
    check("wr_line_done", done_cnt - d0, 1);
    check("wr_sb_drained", sb.size(), 0);

    // Illegal line number
    c0 = ce_cnt;
    d0 = done_cnt;
    line_y     = 8'd192;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (10) tick();
    check("ill_no_ce", ce_cnt - c0, 0);
    check("ill_no_done", done_cnt - d0, 0);
    check("ill_not_busy", line_busy, 0);

    // line_start while busy is ignored
    r0 = rd_cnt;
    d0 = done_cnt;
    push_line(8'd3);
    line_y     = 8'd3;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (20) tick();
    line_y     = 8'd5;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_done(2000);
    tick();
    check("ovl_done_once", done_cnt - d0, 1);
    check("ovl_sb_drained", sb.size(), 0);
    repeat (10) tick();
    check("ovl_reads", rd_cnt - r0, 128);
    check("ovl_not_busy", line_busy, 0);

    // Async reset during AT_DATA of the first cell
    d0 = done_cnt;
    line_y     = 8'd4;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (3) tick();
    check("pre_rst_ce", ce, 1);
    check("pre_rst_ad", ad, 13'h1800);
    #2 reset = 1'b1;
    #1;
    check("arst_ce", ce, 0);
    check("arst_valid", cell_valid, 0);
    check("arst_busy", line_busy, 0);
    check("arst_ad", ad, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("arst_no_done", done_cnt - d0, 0);
    run_line(8'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
